// File: rtl/kf6845_video_timing_decoder.sv
// KF6845 video timing decoder: recovers line/field timing
// from CRTC syncs and reports field parity, interlace, lock.
module kf6845_video_timing_decoder (
  input  logic       clock,
  input  logic       reset,
  input  logic       video_clock_enable,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       display_enable,
  output logic [7:0] line_length,
  output logic [9:0] total_lines,
  output logic [9:0] displayed_lines,
  output logic [4:0] vsync_width,
  output logic [9:0] current_line,
  output logic       field,
  output logic       interlaced,
  output logic       locked,
  output logic       frame_valid,
  output logic       no_signal
);

  logic       r_hsync_d;
  logic       r_vsync_d;
  logic [7:0] r_h_count;
  logic [7:0] r_line_length;
  logic [9:0] r_v_count;
  logic [9:0] r_de_count;
  logic       r_de_seen;
  logic [9:0] r_total;
  logic [9:0] r_disp;
  logic [9:0] r_t1;
  logic [9:0] r_t2;
  logic [4:0] r_vs_cnt;
  logic [4:0] r_vs_width;
  logic [1:0] r_fields_seen;
  logic       r_field;
  logic       r_interlaced;
  logic       r_locked;
  logic       r_frame_valid;
  logic       r_no_signal;

  logic       w_en;
  logic       w_hrise;
  logic       w_vrise;
  logic       w_vfall;
  logic       w_first;
  logic [7:0] w_h_inc;
  logic [9:0] w_v_inc;
  logic       w_de_hit;
  logic [9:0] w_de_inc;
  logic [9:0] w_p4;
  logic [9:0] w_l1;
  logic [9:0] w_l3;
  logic       w_even;
  logic       w_parity;

  assign w_en    = video_clock_enable;
  assign w_hrise = w_en & hsync & ~r_hsync_d;
  assign w_vrise = w_en & vsync & ~r_vsync_d;
  assign w_vfall = w_en & ~vsync & r_vsync_d;
  assign w_first = (r_fields_seen == 2'd0);

  assign w_h_inc = (r_h_count == 8'hFF) ? 8'hFF
                 : r_h_count + 8'd1;

  // line count including an hsync rise on this cycle
  always_comb begin
    w_v_inc = r_v_count;
    if (w_hrise && r_v_count != 10'h3FF)
      w_v_inc = r_v_count + 10'd1;
  end

  assign w_de_hit = w_hrise & (r_de_seen | display_enable);

  // display line count including this cycle's line close
  always_comb begin
    w_de_inc = r_de_count;
    if (w_de_hit && r_de_count != 10'h3FF)
      w_de_inc = r_de_count + 10'd1;
  end

  // half-line offset of the vsync rise marks an even field
  assign w_p4     = {r_h_count, 2'b00};
  assign w_l1     = {2'b00, r_line_length};
  assign w_l3     = w_l1 + {1'b0, r_line_length, 1'b0};
  assign w_even   = (w_p4 >= w_l1) && (w_p4 < w_l3);
  assign w_parity = ~w_even;

  // sync history for edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hsync_d <= 1'b0;
      r_vsync_d <= 1'b0;
    end else if (w_en) begin
      r_hsync_d <= hsync;
      r_vsync_d <= vsync;
    end
  end

  // horizontal counter and measured line length
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_h_count     <= 8'd0;
      r_line_length <= 8'd0;
    end else if (w_en) begin
      if (w_hrise) begin
        r_line_length <= w_h_inc;
        r_h_count     <= 8'd0;
      end else begin
        r_h_count <= w_h_inc;
      end
    end
  end

  // live line and displayed-line counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_v_count  <= 10'd0;
      r_de_count <= 10'd0;
      r_de_seen  <= 1'b0;
    end else if (w_en) begin
      if (w_vrise) begin
        r_v_count  <= 10'd0;
        r_de_count <= 10'd0;
      end else begin
        r_v_count  <= w_v_inc;
        r_de_count <= w_de_inc;
      end
      if (w_hrise)
        r_de_seen <= 1'b0;
      else if (display_enable)
        r_de_seen <= 1'b1;
    end
  end

  // vsync width in lines, latched on the falling edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vs_cnt   <= 5'd0;
      r_vs_width <= 5'd0;
    end else if (w_en) begin
      if (w_vrise)
        r_vs_cnt <= 5'd1;
      else if (r_vsync_d && w_hrise && vsync
               && r_vs_cnt != 5'h1F)
        r_vs_cnt <= r_vs_cnt + 5'd1;
      if (w_vfall)
        r_vs_width <= r_vs_cnt;
    end
  end

  // one-clock pulse on every vsync rise but the first
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_frame_valid <= 1'b0;
    else
      r_frame_valid <= w_vrise & ~w_first;
  end

  // field results, history, lock and no-signal status
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_total       <= 10'd0;
      r_disp        <= 10'd0;
      r_t1          <= 10'd0;
      r_t2          <= 10'd0;
      r_fields_seen <= 2'd0;
      r_field       <= 1'b1;
      r_interlaced  <= 1'b0;
      r_locked      <= 1'b0;
      r_no_signal   <= 1'b0;
    end else if (w_en) begin
      if (w_vrise) begin
        r_field     <= w_parity;
        r_no_signal <= 1'b0;
        if (r_fields_seen != 2'd3)
          r_fields_seen <= r_fields_seen + 2'd1;
        if (!w_first) begin
          r_total      <= w_v_inc;
          r_disp       <= w_de_inc;
          r_interlaced <= (w_parity != r_field);
          r_t2         <= r_t1;
          r_t1         <= w_v_inc;
          r_locked     <= (r_fields_seen == 2'd3)
                          && (w_v_inc == r_t2);
        end
      end else if (w_hrise && w_v_inc == 10'h3FF) begin
        r_no_signal <= 1'b1;
        r_locked    <= 1'b0;
      end
    end
  end

  assign line_length     = r_line_length;
  assign total_lines     = r_total;
  assign displayed_lines = r_disp;
  assign vsync_width     = r_vs_width;
  assign current_line    = r_v_count;
  assign field           = r_field;
  assign interlaced      = r_interlaced;
  assign locked          = r_locked;
  assign frame_valid     = r_frame_valid;
  assign no_signal       = r_no_signal;

endmodule

// File: tb/tb_kf6845_video_timing_decoder.sv
// Bench for kf6845_video_timing_decoder: synthetic CRTC
// sync streams with hand-computed expected measurements.
module tb_kf6845_video_timing_decoder;

  localparam int LL = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       video_clock_enable;
  logic       hsync;
  logic       vsync;
  logic       display_enable;
  logic [7:0] line_length;
  logic [9:0] total_lines;
  logic [9:0] displayed_lines;
  logic [4:0] vsync_width;
  logic [9:0] current_line;
  logic       field;
  logic       interlaced;
  logic       locked;
  logic       frame_valid;
  logic       no_signal;

  int  checks = 0;
  int  errors = 0;
  int  fv_cnt = 0;
  int  fv0;
  bit  vs_level = 1'b0;

  typedef struct {
    int p;
    bit exp_field;
  } ph_t;

  ph_t ph [7];

  kf6845_video_timing_decoder dut (
    .clock              (clock),
    .reset              (reset),
    .video_clock_enable (video_clock_enable),
    .hsync              (hsync),
    .vsync              (vsync),
    .display_enable     (display_enable),
    .line_length        (line_length),
    .total_lines        (total_lines),
    .displayed_lines    (displayed_lines),
    .vsync_width        (vsync_width),
    .current_line       (current_line),
    .field              (field),
    .interlaced         (interlaced),
    .locked             (locked),
    .frame_valid        (frame_valid),
    .no_signal          (no_signal)
  );

  always #5 clock = ~clock;

  always @(negedge clock)
    if (frame_valid) fv_cnt++;

  task automatic chk(input string name,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d",
               name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " line_length"}, line_length, 0);
    chk({tag, " total_lines"}, total_lines, 0);
    chk({tag, " displayed"}, displayed_lines, 0);
    chk({tag, " vsync_width"}, vsync_width, 0);
    chk({tag, " current_line"}, current_line, 0);
    chk({tag, " field"}, field, 1);
    chk({tag, " interlaced"}, interlaced, 0);
    chk({tag, " locked"}, locked, 0);
    chk({tag, " frame_valid"}, frame_valid, 0);
    chk({tag, " no_signal"}, no_signal, 0);
  endtask

  task automatic step(input bit h, input bit v,
                      input bit d, input bit e);
    hsync              = h;
    vsync              = v;
    display_enable     = d;
    video_clock_enable = e;
    @(posedge clock);
    #1;
  endtask

  task automatic line(input int len, input bit de_on,
                      input int set_clk, input bit set_val,
                      input int k0);
    int hw;
    hw = (len >= 80) ? 8 : 2;
    for (int k = k0; k < len; k++) begin
      if (k == set_clk) vs_level = set_val;
      step(k < hw, vs_level,
           de_on && k >= 3 && k < len - 4, 1'b1);
    end
  endtask

  task automatic frame(input int n, input int vs_clk,
                       input int k0);
    for (int l = 0; l < n; l++) begin
      if (l == 0)
        line(LL, l < 200, vs_clk, 1'b1, k0);
      else if (l == 3)
        line(LL, l < 200, vs_clk, 1'b0, 0);
      else
        line(LL, l < 200, -1, 1'b0, 0);
    end
  endtask

  initial begin
    ph[0] = '{19, 1'b1};
    ph[1] = '{20, 1'b0};
    ph[2] = '{59, 1'b0};
    ph[3] = '{60, 1'b1};
    ph[4] = '{0,  1'b1};
    ph[5] = '{39, 1'b0};
    ph[6] = '{78, 1'b1};

    reset = 1'b1;
    hsync = 1'b0;
    vsync = 1'b0;
    display_enable = 1'b0;
    video_clock_enable = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk_reset("rst");
    reset = 1'b0;

    // enable low: inputs ignored
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("gate current_line", current_line, 0);
    chk("gate line_length", line_length, 0);
    chk("gate vsync_width", vsync_width, 0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("en hrise current_line", current_line, 1);
    chk("en hrise line_length", line_length, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // progressive, vsync aligned to hsync rise
    frame(262, 0, 0);
    chk("prog1 fv", fv_cnt, 0);
    chk("prog1 current_line", current_line, 261);
    frame(262, 0, 0);
    chk("prog2 line_length", line_length, LL);
    chk("prog2 total", total_lines, 262);
    chk("prog2 displayed", displayed_lines, 200);
    chk("prog2 vsync_width", vsync_width, 3);
    chk("prog2 field", field, 1);
    chk("prog2 interlaced", interlaced, 0);
    chk("prog2 locked", locked, 0);
    chk("prog2 fv", fv_cnt, 1);
    frame(262, 0, 0);
    chk("prog3 locked", locked, 0);
    frame(262, 0, 0);
    chk("prog4 locked", locked, 1);
    chk("prog4 fv", fv_cnt, 3);

    // hrise and vrise in the same cycle
    vs_level = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("sim current_line", current_line, 0);
    chk("sim frame_valid", frame_valid, 1);
    chk("sim total", total_lines, 262);
    chk("sim field", field, 1);
    chk("sim locked", locked, 1);
    line(LL, 1'b1, -1, 1'b0, 1);
    line(LL, 1'b1, -1, 1'b0, 0);
    line(LL, 1'b1, -1, 1'b0, 0);
    line(LL, 1'b1, 0, 1'b0, 0);
    line(LL, 1'b1, -1, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, 1'b1);

    // asynchronous reset mid-field after lock
    #2 reset = 1'b1;
    #1;
    chk_reset("midrst");
    step(1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    vs_level = 1'b0;
    fv0 = fv_cnt;

    // interlaced: alternate aligned and half-line vsync
    frame(262, 0, 0);
    chk("il1 no fv", fv_cnt, fv0);
    chk("il1 field", field, 1);
    frame(263, LL / 2, 0);
    chk("il2 fv", fv_cnt, fv0 + 1);
    chk("il2 field", field, 0);
    chk("il2 total", total_lines, 262);
    chk("il2 vsync_width", vsync_width, 4);
    frame(262, 0, 0);
    chk("il3 field", field, 1);
    chk("il3 interlaced", interlaced, 1);
    chk("il3 total", total_lines, 263);
    chk("il3 locked", locked, 0);
    frame(263, LL / 2, 0);
    chk("il4 field", field, 0);
    chk("il4 interlaced", interlaced, 1);
    chk("il4 total", total_lines, 262);
    chk("il4 locked", locked, 1);
    chk("il4 fv", fv_cnt, fv0 + 3);

    // vsync stops: line counter saturates
    frame(1023, 0, 0);
    chk("ns pre current_line", current_line, 1022);
    chk("ns pre no_signal", no_signal, 0);
    chk("ns pre locked", locked, 1);
    line(LL, 1'b0, -1, 1'b0, 0);
    chk("ns current_line", current_line, 1023);
    chk("ns no_signal", no_signal, 1);
    chk("ns locked", locked, 0);
    line(LL, 1'b0, -1, 1'b0, 0);
    chk("ns hold current_line", current_line, 1023);
    fv0 = fv_cnt;
    line(LL, 1'b0, 0, 1'b1, 0);
    chk("ns clear no_signal", no_signal, 0);
    chk("ns clear fv", fv_cnt, fv0 + 1);
    chk("ns clear total", total_lines, 1023);
    chk("ns clear current_line", current_line, 0);
    line(LL, 1'b0, -1, 1'b0, 0);
    line(LL, 1'b0, 0, 1'b0, 0);

    // field phase boundaries with 80-clock lines
    for (int i = 0; i < 7; i++) begin
      line(80, 1'b0, -1, 1'b0, 0);
      line(80, 1'b0, -1, 1'b0, 0);
      line(80, 1'b0, ph[i].p + 1, 1'b1, 0);
      line(80, 1'b0, -1, 1'b0, 0);
      line(80, 1'b0, 0, 1'b0, 0);
      chk($sformatf("phase p=%0d field", ph[i].p),
          field, ph[i].exp_field);
      if (i == 0)
        chk("phase line_length", line_length, 80);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
